spi_eeprom_slave: RTL and testbench

Behavioral-synthesizable SPI responder emulating the 128-byte serial EEPROM that the SPI master drives, for closed-loop simulation and FPGA self-test. It oversamples SCK/CSN/MOSI with the system clock and decodes WREN/WRDI/RDSR/WRSR/READ/WRITE. It models the status register (WIP, WEL, BP1:0), a 16-byte page buffer and a programmable internal write time. It sits on the SPI pins opposite the master, in place of the physical memory.

---
 rtl/spi_eeprom_slave.sv | 265 ++++++++++++++++++++++++++
 tb/tb_spi_eeprom_slave.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_eeprom_slave.sv
`timescale 1ns/1ps
// spi_eeprom_slave
// SPI mode-0 responder that behaves like a small serial EEPROM. It is used in
// place of the physical memory, opposite an SPI master, for closed-loop
// simulation and FPGA self-test. All SPI pins are oversampled by clk.
//
// Ports
//   clk      system clock, all logic on posedge
//   rst      asynchronous active-high reset
//   sck      SPI clock from master (idle low)
//   csn      chip select, active low
//   mosi     serial data in, MSB first
//   miso     serial data out, MSB first
//   miso_oe  high while the slave drives miso (READ / RDSR data phase)
//   status   {4'b0, bp1, bp0, wel, wip}
module spi_eeprom_slave #(
    parameter int MEM_DEPTH    = 128,
    parameter int PAGE_SIZE    = 16,
    parameter int WRITE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       csn,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic [7:0] status
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int OW = $clog2(PAGE_SIZE);
    localparam int PW = AW - OW;
    localparam int CW = $clog2(WRITE_CYCLES + 1);

    localparam logic [7:0] OP_WRSR  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WREN  = 8'h06;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, RD_DATA, WR_DATA, RDSR_OUT, WRSR_DATA, IGNORE
    } state_t;

    state_t state, state_nxt;

    // ---------------- pin synchronizers and edge detect ----------------
    logic [2:0] sck_q, csn_q;
    logic [1:0] mosi_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q  <= '0;
            csn_q  <= '1;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], sck};
            csn_q  <= {csn_q[1:0], csn};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    logic sck_rise, sck_fall, cs_start, cs_end;
    assign sck_rise =  sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] &  sck_q[2];
    assign cs_start = ~csn_q[1] &  csn_q[2];
    assign cs_end   =  csn_q[1] & ~csn_q[2];

    // ---------------- datapath registers ----------------
    logic [6:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [7:0]    rx_byte;
    logic          byte_done;
    logic [7:0]    op;        // accepted command of this transaction (0 if ignored)
    logic          extra;     // bits clocked after a WREN/WRDI opcode
    logic          got_byte;  // WRSR received a complete data byte
    logic [AW-1:0] addr;
    logic [7:0]    tx_sh;
    logic          wel, wip, pend_sr;
    logic [1:0]    bp, bp_pend;
    logic [CW-1:0] wip_cnt;
    logic [PAGE_SIZE-1:0] byte_valid;
    logic [PW-1:0] wr_page;
    logic [OW-1:0] wr_off;

    logic [7:0] mem [MEM_DEPTH] = '{default: 8'hFF};
    logic [7:0] page_buf [PAGE_SIZE];

    assign rx_byte   = {shreg, mosi_q[1]};
    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign status    = {4'b0000, bp, wel, wip};

    // Block protection: 01 top quarter, 10 top half, 11 everything.
    function automatic logic page_prot(input logic [1:0] b, input logic [PW-1:0] pg);
        case (b)
            2'b00:   return 1'b0;
            2'b01:   return (int'(pg) * PAGE_SIZE) >= (MEM_DEPTH * 3 / 4);
            2'b10:   return (int'(pg) * PAGE_SIZE) >= (MEM_DEPTH / 2);
            default: return 1'b1;
        endcase
    endfunction

    logic aligned, wr_commit, sr_commit, wel_set, wel_clr, wip_done;
    assign aligned   = (bit_cnt == 3'd0);
    assign wr_commit = (state == WR_DATA) && wel && (|byte_valid) && aligned
                       && !page_prot(bp, wr_page);
    assign sr_commit = (state == WRSR_DATA) && wel && got_byte && aligned;
    assign wel_set   = (state == IGNORE) && (op == OP_WREN) && !extra && aligned;
    assign wel_clr   = (state == IGNORE) && (op == OP_WRDI) && !extra && aligned;
    assign wip_done  = wip && (wip_cnt == CW'(1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs_end) begin
            state_nxt = IDLE;
        end else if (cs_start) begin
            state_nxt = CMD;
        end else if (byte_done) begin
            case (state)
                CMD: begin
                    if (wip && rx_byte != OP_RDSR) begin
                        state_nxt = IGNORE;
                    end else begin
                        case (rx_byte)
                            OP_WREN, OP_WRDI:  state_nxt = IGNORE;
                            OP_RDSR:           state_nxt = RDSR_OUT;
                            OP_WRSR:           state_nxt = WRSR_DATA;
                            OP_READ, OP_WRITE: state_nxt = ADDR;
                            default:           state_nxt = IGNORE;
                        endcase
                    end
                end
                ADDR:    state_nxt = (op == OP_READ) ? RD_DATA : WR_DATA;
                default: state_nxt = state;
            endcase
        end
    end

    // ---------------- control / status ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            op         <= '0;
            extra      <= 1'b0;
            got_byte   <= 1'b0;
            addr       <= '0;
            tx_sh      <= '0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            wel        <= 1'b0;
            wip        <= 1'b0;
            pend_sr    <= 1'b0;
            bp         <= '0;
            bp_pend    <= '0;
            wip_cnt    <= '0;
            byte_valid <= '0;
            wr_page    <= '0;
            wr_off     <= '0;
        end else begin
            if (sck_rise) begin
                shreg   <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
                if (state == IGNORE) extra <= 1'b1;
            end

            if (byte_done) begin
                case (state)
                    CMD: begin
                        op <= (wip && rx_byte != OP_RDSR) ? 8'h00 : rx_byte;
                        if (rx_byte == OP_RDSR) tx_sh <= status;
                    end
                    ADDR: begin
                        if (op == OP_READ) begin
                            tx_sh <= mem[rx_byte[AW-1:0]];
                            addr  <= rx_byte[AW-1:0] + 1'b1;
                        end else begin
                            wr_page <= rx_byte[AW-1:OW];
                            wr_off  <= rx_byte[OW-1:0];
                        end
                    end
                    RD_DATA: begin
                        tx_sh <= mem[addr];
                        addr  <= addr + 1'b1;
                    end
                    RDSR_OUT: tx_sh <= status;
                    WR_DATA: begin
                        byte_valid[wr_off] <= 1'b1;
                        wr_off             <= wr_off + 1'b1;
                    end
                    WRSR_DATA: begin
                        bp_pend  <= rx_byte[3:2];
                        got_byte <= 1'b1;
                    end
                    default: ;
                endcase
            end

            // Output bits change on the falling edge so the master samples
            // stable data on the next rising edge.
            if (sck_fall && (state == RD_DATA || state == RDSR_OUT)) begin
                miso    <= tx_sh[7];
                tx_sh   <= {tx_sh[6:0], 1'b0};
                miso_oe <= 1'b1;
            end

            if (cs_start) begin
                bit_cnt  <= '0;
                op       <= '0;
                extra    <= 1'b0;
                got_byte <= 1'b0;
                miso     <= 1'b0;
                miso_oe  <= 1'b0;
                // The page buffer is still owed to mem while WIP is high.
                if (!wip) byte_valid <= '0;
            end

            if (cs_end) begin
                miso    <= 1'b0;
                miso_oe <= 1'b0;
                if (wr_commit) begin
                    wip     <= 1'b1;
                    wip_cnt <= CW'(WRITE_CYCLES);
                    pend_sr <= 1'b0;
                end else if (sr_commit) begin
                    wip     <= 1'b1;
                    wip_cnt <= CW'(WRITE_CYCLES);
                    pend_sr <= 1'b1;
                end else if (wel_set) begin
                    wel <= 1'b1;
                end else if (wel_clr) begin
                    wel <= 1'b0;
                end
            end

            if (wip_done) begin
                wip        <= 1'b0;
                wip_cnt    <= '0;
                wel        <= 1'b0;
                byte_valid <= '0;
                if (pend_sr) bp <= bp_pend;
            end else if (wip) begin
                wip_cnt <= wip_cnt - 1'b1;
            end
        end
    end

    // ---------------- storage (not reset) ----------------
    always_ff @(posedge clk) begin
        if (byte_done && state == WR_DATA) page_buf[wr_off] <= rx_byte;
        if (wip_done && !pend_sr) begin
            for (int i = 0; i < PAGE_SIZE; i++) begin
                if (byte_valid[i]) mem[{wr_page, OW'(i)}] <= page_buf[i];
            end
        end
    end

endmodule

// File: tb/tb_spi_eeprom_slave.sv
`timescale 1ns/1ps
// Directed bench for spi_eeprom_slave: a bit-banged SPI master drives
// command sequences and every observation is compared with a hand-derived
// constant.
module tb_spi_eeprom_slave;
    localparam int WC   = 400;  // internal write time used for this bench
    localparam int HALF = 6;    // clk cycles per SCK half period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       csn = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic [7:0] status;

    int checks   = 0;
    int failures = 0;
    int wip_len  = 0;

    spi_eeprom_slave #(.MEM_DEPTH(128), .PAGE_SIZE(16), .WRITE_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .sck(sck), .csn(csn), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .status(status)
    );

    always #5 clk = ~clk;

    // Cycles during which WIP is high, sampled away from the active edge.
    always @(negedge clk) if (status[0]) wip_len = wip_len + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic spi_begin();
        csn = 1'b0;
        clks(HALF);
    endtask

    task automatic spi_end();
        clks(HALF);
        csn = 1'b1;
        clks(2 * HALF);
    endtask

    // Clocks the top n bits of tx; rx collects miso sampled before each rise.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = tx[i];
            clks(HALF);
            rx[i] = miso;
            sck = 1'b1;
            clks(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic cmd1(input logic [7:0] c);
        logic [7:0] r;
        spi_begin();
        xfer(c, r);
        spi_end();
    endtask

    task automatic write1(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] r;
        spi_begin();
        xfer(8'h02, r);
        xfer(a, r);
        xfer(d, r);
        spi_end();
    endtask

    task automatic read2(input logic [7:0] a, output logic [7:0] d0, output logic [7:0] d1);
        logic [7:0] r;
        spi_begin();
        xfer(8'h03, r);
        xfer(a, r);
        xfer(8'h00, d0);
        xfer(8'h00, d1);
        spi_end();
    endtask

    task automatic wait_wip(input string tag);
        int n = 0;
        while (status[0] && n < 4 * WC) begin
            clks(1);
            n++;
        end
        chk(tag, {7'b0, status[0]}, 8'h00);
    endtask

    initial begin
        logic [7:0] r, d0, d1;
        int polls;
        logic seen_clear;

        // reset state
        clks(4);
        chk("rst_status", status, 8'h00);
        chk("rst_miso_oe", {7'b0, miso_oe}, 8'h00);
        chk("rst_miso", {7'b0, miso}, 8'h00);
        rst = 1'b0;
        clks(4);

        // WREN then RDSR
        cmd1(8'h06);
        chk("wren_status", status, 8'h02);
        spi_begin();
        xfer(8'h05, r);
        chk("rdsr_cmd_phase_miso", r, 8'h00);
        xfer(8'h00, r);
        chk("rdsr_byte", r, 8'h02);
        chk("rdsr_oe_high", {7'b0, miso_oe}, 8'h01);
        spi_end();
        chk("rdsr_oe_low", {7'b0, miso_oe}, 8'h00);

        // WRITE 0x10 <= A5,5A, poll WIP, read back
        wip_len = 0;
        spi_begin();
        xfer(8'h02, r); xfer(8'h10, r); xfer(8'hA5, r); xfer(8'h5A, r);
        spi_end();
        chk("write_status_busy", status, 8'h03);
        spi_begin();
        xfer(8'h05, r);
        xfer(8'h00, r);
        chk("poll_first_busy", r, 8'h03);
        polls = 0;
        seen_clear = 1'b0;
        while (!seen_clear && polls < 20) begin
            xfer(8'h00, r);
            if (r == 8'h00) seen_clear = 1'b1;
            else chk("poll_busy_value", r, 8'h03);
            polls++;
        end
        spi_end();
        chk("poll_reached_clear", {7'b0, seen_clear}, 8'h01);
        chk("wip_len", wip_len[7:0], 8'(WC));
        chk("wip_len_hi", wip_len[15:8], 8'(WC >> 8));
        chk("post_write_status", status, 8'h00);
        read2(8'h10, d0, d1);
        chk("read_10", d0, 8'hA5);
        chk("read_11", d1, 8'h5A);

        // WRITE without WREN is discarded
        write1(8'h20, 8'h11);
        chk("nowren_status", status, 8'h00);
        read2(8'h20, d0, d1);
        chk("nowren_read", d0, 8'hFF);

        // address wraparound on READ
        cmd1(8'h06);
        write1(8'h7F, 8'hC3);
        wait_wip("wip_7f");
        cmd1(8'h06);
        write1(8'h00, 8'h3C);
        wait_wip("wip_00");
        read2(8'h7F, d0, d1);
        chk("wrap_7f", d0, 8'hC3);
        chk("wrap_00", d1, 8'h3C);

        // block protection BP=10
        cmd1(8'h06);
        spi_begin();
        xfer(8'h01, r); xfer(8'h08, r);
        spi_end();
        chk("wrsr_busy", status, 8'h03);
        wait_wip("wip_wrsr");
        chk("bp10_status", status, 8'h08);
        cmd1(8'h06);
        write1(8'h50, 8'h77);
        chk("prot_discard_status", status, 8'h0A);
        read2(8'h50, d0, d1);
        chk("prot_read_50", d0, 8'hFF);
        write1(8'h30, 8'h77);
        chk("unprot_busy", status, 8'h0B);
        wait_wip("wip_30");
        read2(8'h30, d0, d1);
        chk("unprot_read_30", d0, 8'h77);
        cmd1(8'h06);
        spi_begin();
        xfer(8'h01, r); xfer(8'h00, r);
        spi_end();
        wait_wip("wip_bp_clear");
        chk("bp_cleared", status, 8'h00);

        // partial data byte: no commit, WEL kept
        cmd1(8'h06);
        spi_begin();
        xfer(8'h02, r); xfer(8'h00, r);
        spi_bits(8'hF0, 4, r);
        spi_end();
        chk("partial_no_commit", status, 8'h02);
        cmd1(8'h04);
        chk("wrdi_clears", status, 8'h00);
        spi_begin();
        xfer(8'h06, r);
        spi_bits(8'h80, 1, r);
        spi_end();
        chk("wren_9bits_rejected", status, 8'h00);

        // reset in the middle of WIP aborts the write
        cmd1(8'h06);
        write1(8'h10, 8'h99);
        chk("abort_busy", status, 8'h03);
        clks(50);
        rst = 1'b1;
        clks(3);
        chk("abort_status", status, 8'h00);
        rst = 1'b0;
        clks(WC + 50);
        read2(8'h10, d0, d1);
        chk("abort_mem_kept", d0, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
